// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs and pipeline control outputs.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       rs1ID;
    logic [2:0]       rs2ID;
    logic             useRs1ID;
    logic             useRs2ID;
    logic             branchID;
    logic             takenID;
    logic [2:0]       rdEX;
    logic             regWriteEX;
    logic             memReadEX;
    logic [2:0]       rdMEM;
    logic             memReadMEM;
    logic             memWait;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexBubble;
    logic             pipeFreeze;
    logic             stalling;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    // Pipeline side: drives hazard information, consumes control
    modport master (
        output rs1ID, rs2ID, useRs1ID, useRs2ID, branchID, takenID,
        output rdEX, regWriteEX, memReadEX, rdMEM, memReadMEM, memWait,
        input  pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, stalling,
        input  stallCount, flushCount
    );

    // Controller side
    modport slave (
        input  rs1ID, rs2ID, useRs1ID, useRs2ID, branchID, takenID,
        input  rdEX, regWriteEX, memReadEX, rdMEM, memReadMEM, memWait,
        output pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, stalling,
        output stallCount, flushCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and ID-branch stalls, taken-branch
// flush, memory-wait freeze, saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           saved;
    state_t           resume;
    logic [1:0]       remain;
    logic [1:0]       need;
    logic             started;
    logic             inert;
    logic             m_ex;
    logic             m_mem;
    logic             stall_hit;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             stall_act;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Outputs hold their reset values during reset and for the first cycle after it
    assign inert = reset | ~started;

    // State to continue from once a memory freeze lifts
    assign resume = (state == ST_FREEZE) ? saved : state;

    // Required stall length from operand matches, highest-priority rule first
    always_comb begin
        m_ex  = (bus.useRs1ID & (bus.rs1ID == bus.rdEX))
              | (bus.useRs2ID & (bus.rs2ID == bus.rdEX));
        m_mem = (bus.useRs1ID & (bus.rs1ID == bus.rdMEM))
              | (bus.useRs2ID & (bus.rs2ID == bus.rdMEM));
        need  = 2'd0;
        if (bus.branchID & bus.memReadEX & m_ex) begin
            need = 2'd2;
        end else if (bus.memReadEX & bus.regWriteEX & m_ex) begin
            need = 2'd1;
        end else if (bus.branchID & bus.regWriteEX & m_ex) begin
            need = 2'd1;
        end else if (bus.branchID & bus.memReadMEM & m_mem) begin
            need = 2'd1;
        end
    end

    assign stall_hit = (resume == ST_STALL) || ((resume == ST_RUN) && (need != 2'd0));

    // Zero-latency control outputs; memWait overrides any stall or flush
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        stall_act   = 1'b0;
        if (inert) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.memWait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_act   = 1'b1;
        end else begin
            ifid_flush  = bus.branchID & bus.takenID;
        end
    end

    // FSM sequencing and saturating performance counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            saved       <= ST_RUN;
            remain      <= 2'd0;
            started     <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            started <= 1'b1;
            if (!inert) begin
                if (bus.memWait) begin
                    state <= ST_FREEZE;
                    if (state != ST_FREEZE) begin
                        saved <= state;
                    end
                end else if (resume == ST_STALL) begin
                    if (remain > 2'd1) begin
                        remain <= remain - 2'd1;
                        state  <= ST_STALL;
                    end else begin
                        remain <= 2'd0;
                        state  <= ST_RUN;
                    end
                end else if (need != 2'd0) begin
                    remain <= need - 2'd1;
                    state  <= (need == 2'd2) ? ST_STALL : ST_RUN;
                end else begin
                    state <= ST_RUN;
                end
            end
            if (stall_act && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    assign bus.pcWrite    = pc_write;
    assign bus.ifidWrite  = ifid_write;
    assign bus.ifidFlush  = ifid_flush;
    assign bus.idexBubble = idex_bubble;
    assign bus.pipeFreeze = pipe_freeze;
    assign bus.stalling   = stall_act;
    assign bus.stallCount = stall_count;
    assign bus.flushCount = flush_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a stall-debt reference model. Two instances (4-bit and
// 16-bit counters) share the same stimulus.
module tb_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] rs1, rs2, rd_ex, rd_mem;
    logic       use1, use2, br, tk, rw_ex, mr_ex, mr_mem, mw;

    hazard_ctrl_if #(.CNT_W(4))  bus4 ();
    hazard_ctrl_if #(.CNT_W(16)) bus16 ();

    // Same stimulus to both instances
    always_comb begin
        bus4.rs1ID       = rs1;     bus16.rs1ID       = rs1;
        bus4.rs2ID       = rs2;     bus16.rs2ID       = rs2;
        bus4.useRs1ID    = use1;    bus16.useRs1ID    = use1;
        bus4.useRs2ID    = use2;    bus16.useRs2ID    = use2;
        bus4.branchID    = br;      bus16.branchID    = br;
        bus4.takenID     = tk;      bus16.takenID     = tk;
        bus4.rdEX        = rd_ex;   bus16.rdEX        = rd_ex;
        bus4.regWriteEX  = rw_ex;   bus16.regWriteEX  = rw_ex;
        bus4.memReadEX   = mr_ex;   bus16.memReadEX   = mr_ex;
        bus4.rdMEM       = rd_mem;  bus16.rdMEM       = rd_mem;
        bus4.memReadMEM  = mr_mem;  bus16.memReadMEM  = mr_mem;
        bus4.memWait     = mw;      bus16.memWait     = mw;
    end

    hazard_ctrl #(.CNT_W(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));
    hazard_ctrl #(.CNT_W(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding stall cycles owed, plus plain counters
    int   m_left = 0;
    bit   m_hold = 1'b0;
    int   m_sc4 = 0, m_fc4 = 0, m_sc16 = 0, m_fc16 = 0;
    int   need;
    bit   mex, mmem;
    logic e_pc, e_if, e_bub, e_fl, e_frz, e_st;

    task automatic cmp(input string tag, input logic pc, input logic ifw, input logic bub,
                       input logic fl, input logic frz, input logic st,
                       input logic [15:0] sc, input logic [15:0] fc, input int esc, input int efc);
        chk({tag, ".pcWrite"},    32'(pc),  32'(e_pc));
        chk({tag, ".ifidWrite"},  32'(ifw), 32'(e_if));
        chk({tag, ".idexBubble"}, 32'(bub), 32'(e_bub));
        chk({tag, ".ifidFlush"},  32'(fl),  32'(e_fl));
        chk({tag, ".pipeFreeze"}, 32'(frz), 32'(e_frz));
        chk({tag, ".stalling"},   32'(st),  32'(e_st));
        chk({tag, ".stallCount"}, 32'(sc),  32'(esc));
        chk({tag, ".flushCount"}, 32'(fc),  32'(efc));
    endtask

    // Compare process: outputs are sampled mid-cycle, model advances afterwards
    always @(negedge clock) begin
        e_pc = 1'b1; e_if = 1'b1; e_bub = 1'b0; e_fl = 1'b0; e_frz = 1'b0; e_st = 1'b0;
        if (reset || m_hold) begin
            if (reset) begin
                m_left = 0; m_hold = 1'b1;
                m_sc4 = 0; m_fc4 = 0; m_sc16 = 0; m_fc16 = 0;
            end else begin
                m_hold = 1'b0;
            end
            e_pc = 1'b0; e_if = 1'b0; e_bub = 1'b1;
        end else begin
            mex  = (use1 && rs1 == rd_ex)  || (use2 && rs2 == rd_ex);
            mmem = (use1 && rs1 == rd_mem) || (use2 && rs2 == rd_mem);
            if (br && mr_ex && mex)          need = 2;
            else if (mr_ex && rw_ex && mex)  need = 1;
            else if (br && rw_ex && mex)     need = 1;
            else if (br && mr_mem && mmem)   need = 1;
            else                             need = 0;
            if (mw) begin
                e_pc = 1'b0; e_if = 1'b0; e_frz = 1'b1;
            end else if (m_left > 0 || need > 0) begin
                e_pc = 1'b0; e_if = 1'b0; e_bub = 1'b1; e_st = 1'b1;
                m_left = (m_left > 0) ? m_left - 1 : need - 1;
            end else begin
                e_fl = br && tk;
            end
        end
        cmp("w4",  bus4.pcWrite, bus4.ifidWrite, bus4.idexBubble, bus4.ifidFlush,
            bus4.pipeFreeze, bus4.stalling, 16'(bus4.stallCount), 16'(bus4.flushCount),
            m_sc4, m_fc4);
        cmp("w16", bus16.pcWrite, bus16.ifidWrite, bus16.idexBubble, bus16.ifidFlush,
            bus16.pipeFreeze, bus16.stalling, bus16.stallCount, bus16.flushCount,
            m_sc16, m_fc16);
        if (e_st) begin
            m_sc4  = (m_sc4  < 15)    ? m_sc4  + 1 : 15;
            m_sc16 = (m_sc16 < 65535) ? m_sc16 + 1 : 65535;
        end
        if (e_fl) begin
            m_fc4  = (m_fc4  < 15)    ? m_fc4  + 1 : 15;
            m_fc16 = (m_fc16 < 65535) ? m_fc16 + 1 : 65535;
        end
    end

    task automatic clear_in();
        rs1 = 3'd0; rs2 = 3'd0; rd_ex = 3'd0; rd_mem = 3'd0;
        use1 = 1'b0; use2 = 1'b0; br = 1'b0; tk = 1'b0;
        rw_ex = 1'b0; mr_ex = 1'b0; mr_mem = 1'b0; mw = 1'b0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic load_use();
        clear_in();
        mr_ex = 1'b1; rw_ex = 1'b1; rd_ex = 3'd3; rs1 = 3'd3; use1 = 1'b1;
    endtask

    task automatic branch_on_load();
        clear_in();
        br = 1'b1; tk = 1'b1; mr_ex = 1'b1; rw_ex = 1'b1; rd_ex = 3'd2; rs2 = 3'd2; use2 = 1'b1;
    endtask

    initial begin
        clear_in();
        #1 reset = 1'b1;
        #1;
        chk("rst.pcWrite",    32'(bus16.pcWrite), 32'd0);
        chk("rst.idexBubble", 32'(bus16.idexBubble), 32'd1);
        chk("rst.stalling",   32'(bus16.stalling), 32'd0);
        chk("rst.stallCount", 32'(bus16.stallCount), 32'd0);
        repeat (2) next();
        reset = 1'b0;
        settle();
        chk("postrst.pcWrite",    32'(bus16.pcWrite), 32'd0);
        chk("postrst.idexBubble", 32'(bus16.idexBubble), 32'd1);
        next(); settle();
        chk("idle.pcWrite",    32'(bus16.pcWrite), 32'd1);
        chk("idle.idexBubble", 32'(bus16.idexBubble), 32'd0);

        // Load-use: one stall cycle
        next(); load_use(); settle();
        chk("lu.pcWrite",    32'(bus16.pcWrite), 32'd0);
        chk("lu.idexBubble", 32'(bus16.idexBubble), 32'd1);
        chk("lu.stalling",   32'(bus16.stalling), 32'd1);
        next(); rd_ex = 3'd5; settle();
        chk("lu_after.pcWrite",    32'(bus16.pcWrite), 32'd1);
        chk("lu_after.idexBubble", 32'(bus16.idexBubble), 32'd0);
        chk("lu_after.stallCount", 32'(bus16.stallCount), 32'd1);

        // Branch on in-flight load: two stall cycles, flush suppressed until after
        next(); branch_on_load(); settle();
        chk("br1.stalling",  32'(bus16.stalling), 32'd1);
        chk("br1.ifidFlush", 32'(bus16.ifidFlush), 32'd0);
        next(); settle();
        chk("br2.stalling",  32'(bus16.stalling), 32'd1);
        chk("br2.ifidFlush", 32'(bus16.ifidFlush), 32'd0);
        next(); clear_in(); br = 1'b1; tk = 1'b1; settle();
        chk("br3.ifidFlush",  32'(bus16.ifidFlush), 32'd1);
        chk("br3.stalling",   32'(bus16.stalling), 32'd0);
        chk("br3.stallCount", 32'(bus16.stallCount), 32'd3);
        next(); clear_in(); settle();
        chk("br4.ifidFlush",  32'(bus16.ifidFlush), 32'd0);
        chk("br4.flushCount", 32'(bus16.flushCount), 32'd1);

        // Unused source never stalls
        next(); clear_in(); rd_ex = 3'd4; rs1 = 3'd4; mr_ex = 1'b1; rw_ex = 1'b1; settle();
        chk("nouse.pcWrite",    32'(bus16.pcWrite), 32'd1);
        chk("nouse.ifidWrite",  32'(bus16.ifidWrite), 32'd1);
        chk("nouse.idexBubble", 32'(bus16.idexBubble), 32'd0);
        next(); clear_in(); settle();
        chk("nouse.stallCount", 32'(bus16.stallCount), 32'd3);

        // memWait inside a 2-cycle stall
        next(); branch_on_load(); settle();
        chk("mw0.stalling", 32'(bus16.stalling), 32'd1);
        for (int i = 0; i < 3; i++) begin
            next(); mw = 1'b1; settle();
            chk("mw.pipeFreeze", 32'(bus16.pipeFreeze), 32'd1);
            chk("mw.stalling",   32'(bus16.stalling), 32'd0);
            chk("mw.stallCount", 32'(bus16.stallCount), 32'd4);
        end
        next(); mw = 1'b0; settle();
        chk("mw_end.stalling",   32'(bus16.stalling), 32'd1);
        chk("mw_end.pipeFreeze", 32'(bus16.pipeFreeze), 32'd0);
        next(); clear_in(); settle();
        chk("mw_done.stalling",   32'(bus16.stalling), 32'd0);
        chk("mw_done.stallCount", 32'(bus16.stallCount), 32'd5);

        // Reset while in STALL
        next(); branch_on_load(); settle();
        next(); reset = 1'b1; #1;
        chk("rstst.pcWrite",    32'(bus16.pcWrite), 32'd0);
        chk("rstst.idexBubble", 32'(bus16.idexBubble), 32'd1);
        chk("rstst.stalling",   32'(bus16.stalling), 32'd0);
        chk("rstst.stallCount", 32'(bus16.stallCount), 32'd0);
        #4;
        next(); reset = 1'b0; clear_in(); settle();
        chk("rstst_hold.pcWrite", 32'(bus16.pcWrite), 32'd0);
        next(); settle();
        chk("rstst_run.pcWrite",    32'(bus16.pcWrite), 32'd1);
        chk("rstst_run.idexBubble", 32'(bus16.idexBubble), 32'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            next(); load_use(); settle();
        end
        next(); clear_in(); settle();
        chk("sat.stallCount4",  32'(bus4.stallCount), 32'd15);
        chk("sat.stallCount16", 32'(bus16.stallCount), 32'd20);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next();
            if (reset) reset = 1'($urandom);
            else       reset = ($urandom_range(0, 299) == 0);
            rs1    = 3'($urandom_range(0, 3));
            rs2    = 3'($urandom_range(0, 3));
            rd_ex  = 3'($urandom_range(0, 3));
            rd_mem = 3'($urandom_range(0, 3));
            use1   = 1'($urandom);
            use2   = 1'($urandom);
            br     = 1'($urandom);
            tk     = 1'($urandom);
            rw_ex  = 1'($urandom);
            mr_ex  = 1'($urandom);
            mr_mem = 1'($urandom);
            mw     = ($urandom_range(0, 5) == 0);
        end
        next(); reset = 1'b0; clear_in();
        repeat (3) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
